// File: rtl/simple_pipe_counter_if.sv
// rtl/simple_pipe_counter_if.sv - enable/count bundle for simple_pipe_counter
//
// Signals:
//   inp1, inp2  per-channel enable operands (driven by master)
//   out         pipelined counts, channel c at [c*WIDTH +: WIDTH] (driven by slave)
//   tc          pipelined terminal-count flags (driven by slave)
interface simple_pipe_counter_if #(
    parameter int CHANNELS = 1,
    parameter int WIDTH    = 1
);
    logic [CHANNELS-1:0]       inp1;
    logic [CHANNELS-1:0]       inp2;
    logic [CHANNELS*WIDTH-1:0] out;
    logic [CHANNELS-1:0]       tc;

    modport master (output inp1, output inp2, input out, input tc);
    modport slave  (input inp1, input inp2, output out, output tc);
endinterface

// File: rtl/simple_pipe_counter.sv
// rtl/simple_pipe_counter.sv - per-channel enabled counters with delayed count/terminal-count outputs
//
// Ports:
//   tau2015_clk  rising-edge clock
//   rst          synchronous reset, active-high; clears counters and every pipeline stage
//   bus          simple_pipe_counter_if.slave: inp1/inp2 in, out/tc out
module simple_pipe_counter #(
    parameter int CHANNELS   = 1,
    parameter int WIDTH      = 1,
    parameter int MODE       = 0,
    parameter int OUT_STAGES = 0
) (
    input  logic                 tau2015_clk,
    input  logic                 rst,
    simple_pipe_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [CHANNELS-1:0]             en;
    logic [CHANNELS-1:0]             tc_raw;
    logic [CHANNELS-1:0][WIDTH-1:0]  cnt_q, cnt_d;
    // tc_raw is registered alongside the counter so that the flag lines up
    // with the edge on which the counter shows 0 after the wrap.
    logic [CHANNELS-1:0]             tc_q, tc_d;

    always_comb begin
        en     = bus.inp1 & bus.inp2;
        tc_raw = '0;
        cnt_d  = cnt_q;
        for (int c = 0; c < CHANNELS; c++) begin
            tc_raw[c] = en[c] && (cnt_q[c] == CNT_MAX);
            if (en[c]) begin
                cnt_d[c] = cnt_q[c] + WIDTH'(1);
            end else if (MODE == 1) begin
                cnt_d[c] = cnt_q[c];
            end else begin
                cnt_d[c] = '0;
            end
        end
        tc_d = tc_raw;
    end

    always_ff @(posedge tau2015_clk) begin
        if (rst) begin
            cnt_q <= '0;
            tc_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    if (OUT_STAGES == 0) begin : g_direct
        assign bus.out = cnt_q;
        assign bus.tc  = tc_q;
    end else begin : g_pipe
        logic [OUT_STAGES-1:0][CHANNELS*WIDTH-1:0] pcnt_q, pcnt_d;
        logic [OUT_STAGES-1:0][CHANNELS-1:0]       ptc_q, ptc_d;

        always_comb begin
            pcnt_d    = pcnt_q;
            ptc_d     = ptc_q;
            pcnt_d[0] = cnt_q;
            ptc_d[0]  = tc_q;
            for (int s = 1; s < OUT_STAGES; s++) begin
                pcnt_d[s] = pcnt_q[s-1];
                ptc_d[s]  = ptc_q[s-1];
            end
        end

        // Whole pipeline clears on the reset edge so no pre-reset count can
        // surface afterwards.
        always_ff @(posedge tau2015_clk) begin
            if (rst) begin
                pcnt_q <= '0;
                ptc_q  <= '0;
            end else begin
                pcnt_q <= pcnt_d;
                ptc_q  <= ptc_d;
            end
        end

        assign bus.out = pcnt_q[OUT_STAGES-1];
        assign bus.tc  = ptc_q[OUT_STAGES-1];
    end
endmodule

// File: doc/simple_pipe_counter.md
Name: simple_pipe_counter

Overview:
- Parametrised successor to the 1-bit NAND/NOR-feedback flop benchmark cell.
- Each of CHANNELS independent channels holds a WIDTH-bit counter. The counter is enabled by the AND of two per-channel inputs.
- Each counter's value and terminal-count flag leave through an OUT_STAGES-deep register pipeline.
- Used as a scalable sequential timing benchmark. The default configuration reproduces the original cell's behaviour at the output.

Parameters:
- CHANNELS, 1, number of independent counter channels (>=1).
- WIDTH, 1, counter width in bits per channel (>=1).
- MODE, 0, idle behaviour when disabled: 0 = synchronous clear to 0 (original cell behaviour); 1 = hold value.
- OUT_STAGES, 0, output pipeline depth in registers (0 = counter register drives outputs directly).

Ports:
- tau2015_clk  input  1  sole clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- inp1  input  CHANNELS  per-channel enable operand A.
- inp2  input  CHANNELS  per-channel enable operand B.
- out  output  CHANNELS*WIDTH  pipelined count; channel c occupies bits [c*WIDTH +: WIDTH].
- tc  output  CHANNELS  pipelined terminal-count flag per channel.

Behaviour:
- Interface: one clock, tau2015_clk. Reset rst is synchronous and active-high. All state updates on the rising edge only.
- Per-channel enable: en[c] = inp1[c] & inp2[c]. This is purely combinational and is not registered before use.
- Counter update, evaluated each edge in priority order:
  - rst=1: cnt <= 0.
  - en=1: cnt <= cnt + 1, modulo 2^WIDTH. All-ones wraps to 0 with no saturation.
  - en=0, MODE=0: cnt <= 0.
  - en=0, MODE=1: cnt <= cnt (hold).
- WIDTH=1, MODE=0 is equivalent to the original cell: q_next = en & ~q.
- Terminal count: tc_raw[c] = en[c] & (cnt[c] == 2^WIDTH-1). It is combinational from the current counter state and inputs, and flags the cycle in which a wrap occurs.
- Output pipeline: the vector {cnt, tc_raw} of each channel passes through OUT_STAGES registers.
  - out lags cnt by OUT_STAGES cycles.
  - tc lags tc_raw by OUT_STAGES+1 relative to the enabling edge. With OUT_STAGES=0, tc is registered once so that it is aligned with out showing 0 after the wrap.
  - Resulting rule: tc=1 in exactly the cycle where out first shows 0 following all-ones.
- Reset values: cnt, every pipeline stage, out and tc are all 0. rst clears the whole pipeline in the same edge.
  - out=0 and tc=0 in the cycle after the rst edge, for any OUT_STAGES.
  - No stale data emerges after reset.
- Reset mid-operation: rst overrides en. Counting resumes from 0 at the first edge with rst=0 and en=1.
- Channels are fully independent: there is no shared state and no cross-channel ordering.
- Simultaneous events:
  - rst with en=1 at all-ones: reset wins; cnt=0 and tc stays 0.
  - en dropping in the wrap cycle does not produce tc, because tc_raw requires en in that cycle.
- No X propagation: all registers are reset, and the pipeline holds no uninitialised state after the first rst edge.

Test Plan:
- Default params, rst 1 cycle, then inp1=inp2=1 for 6 cycles, then inp2=0 -> out toggles 1,0,1,0,1,0 on successive edges; tc=1 on every cycle out returns to 0; out=0 one edge after inp2 drops.
- WIDTH=3, MODE=1, OUT_STAGES=2:
  - en=1 for 5 edges, en=0 for 3 edges, en=1 for 4 edges -> out reaches 5 two cycles late, holds 5, then shows 6,7,0,1.
  - tc=1 only in the cycle out=0.
- WIDTH=3, MODE=0: count to 4, drop inp1 for 1 cycle -> out=0 next edge, then restarts 1,2,... with en=1.
- CHANNELS=4, WIDTH=4: channel 0 always enabled, channel 1 never, channels 2/3 alternating -> after 16 edges, ch0=0 with tc pulse; ch1=0; ch2 and ch3 follow their own enable counts; no crosstalk.
- Reset mid-run, OUT_STAGES=3, WIDTH=4: count to 9, assert rst one cycle with en=1 -> out=0 and tc=0 next cycle, with no 7/8/9 emerging from the pipeline; resumes 1,2,3 (delayed 3) after rst falls.
- WIDTH=2: rst asserted with en=1 on the cycle cnt=3 -> cnt=0, no tc pulse at any later cycle from that wrap.
